// File: rtl/ysyx_22041412_muldiv_ctrl.sv
// Iterative RV64M sequencer: radix-2 shift-add multiply / restoring divide, one bit per cycle.
// Result N+1 cycles after accept (N=64, or 32 for W ops), 1 cycle for div-by-zero/overflow; held until out_ready.
module ysyx_22041412_muldiv_ctrl #(
   parameter int XLEN = 64,
   parameter int WLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      func3,
   input  logic            is_word,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state;

   function automatic logic [XLEN-1:0] wsext(input logic [WLEN-1:0] v);
      return {{(XLEN-WLEN){v[WLEN-1]}}, v};
   endfunction

   function automatic logic [XLEN-1:0] wzext(input logic [WLEN-1:0] v);
      return {{(XLEN-WLEN){1'b0}}, v};
   endfunction

   logic [2:0]        op_f3;
   logic              op_word;
   logic              op_neg;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] mcand;
   logic [XLEN-1:0]   mplier;
   logic [XLEN-1:0]   rem_r;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   dvsr;

   logic            is_div, sgn1, sgn2, s1, s2, div_zero, div_ovf, special;
   logic [XLEN-1:0] ext1, ext2, mag1, mag2, dvd, spec_val;

   always_comb begin
      is_div   = func3[2];
      sgn1     = is_div ? ~func3[0] : (func3[1:0] == 2'b01 || func3[1:0] == 2'b10);
      sgn2     = is_div ? ~func3[0] : (func3[1:0] == 2'b01);
      ext1     = is_word ? (sgn1 ? wsext(src1[WLEN-1:0]) : wzext(src1[WLEN-1:0])) : src1;
      ext2     = is_word ? (sgn2 ? wsext(src2[WLEN-1:0]) : wzext(src2[WLEN-1:0])) : src2;
      s1       = sgn1 & ext1[XLEN-1];
      s2       = sgn2 & ext2[XLEN-1];
      mag1     = s1 ? -ext1 : ext1;
      mag2     = s2 ? -ext2 : ext2;
      dvd      = is_word ? wsext(src1[WLEN-1:0]) : src1;
      div_zero = (ext2 == '0);
      div_ovf  = sgn1 && (ext1 == (is_word ? MIN_W : MIN_X)) && (&ext2);
      special  = is_div && (div_zero || div_ovf);
      // special results are parked in quo/rem_r so the normal result path serves them
      spec_val = func3[1] ? (div_zero ? dvd : '0) : (div_zero ? '1 : dvd);
   end

   logic [XLEN:0]   rem_sh, diff;
   logic [CW-1:0]   last;

   always_comb begin
      rem_sh = {rem_r, quo[XLEN-1]};
      diff   = rem_sh - {1'b0, dvsr};
      last   = op_word ? CW'(WLEN-1) : CW'(XLEN-1);
   end

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   q_s, r_s, d_sel, fin;

   always_comb begin
      prod  = op_neg ? -acc : acc;
      q_s   = op_neg ? -quo : quo;
      r_s   = op_neg ? -rem_r : rem_r;
      d_sel = op_f3[1] ? r_s : q_s;
      if (op_f3[2])
         fin = op_word ? wsext(d_sel[WLEN-1:0]) : d_sel;
      else if (op_f3[1:0] == 2'b00)
         fin = op_word ? wsext(prod[WLEN-1:0]) : prod[XLEN-1:0];
      else
         fin = prod[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         cnt       <= '0;
         op_f3     <= '0;
         op_word   <= 1'b0;
         op_neg    <= 1'b0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         rem_r     <= '0;
         quo       <= '0;
         dvsr      <= '0;
      end else if (flush) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  op_f3    <= func3;
                  op_word  <= is_word;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  acc      <= '0;
                  mcand    <= {{XLEN{1'b0}}, mag1};
                  mplier   <= mag2;
                  dvsr     <= mag2;
                  if (special) begin
                     state  <= DONE;
                     op_neg <= 1'b0;
                     quo    <= spec_val;
                     rem_r  <= spec_val;
                  end else begin
                     state  <= BUSY;
                     op_neg <= (is_div && func3[1]) ? s1 : (s1 ^ s2);
                     rem_r  <= '0;
                     // W dividends are left-aligned so the next bit is always quo's MSB
                     quo    <= is_word ? {mag1[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : mag1;
                  end
               end
            end
            BUSY: begin
               if (mplier[0])
                  acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (!diff[XLEN]) begin
                  rem_r <= diff[XLEN-1:0];
                  quo   <= {quo[XLEN-2:0], 1'b1};
               end else begin
                  rem_r <= rem_sh[XLEN-1:0];
                  quo   <= {quo[XLEN-2:0], 1'b0};
               end
               if (cnt == last) begin
                  state <= DONE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (!out_valid) begin
                  result    <= fin;
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_22041412_muldiv_ctrl.sv
// Bench for ysyx_22041412_muldiv_ctrl: directed cases plus random ops against an arithmetic reference.
module tb_ysyx_22041412_muldiv_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [2:0]  func3;
   logic        is_word;
   logic [63:0] src1, src2;
   logic        flush;
   logic        out_valid, out_ready;
   logic [63:0] result;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [63:0] MIN64 = 64'h8000000000000000;

   ysyx_22041412_muldiv_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .func3(func3), .is_word(is_word), .src1(src1), .src2(src2),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] sx(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] ref_res(input logic [2:0] f, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] pa, pb;
      logic [127:0]        p;
      logic signed [63:0]  sa, sb, sr;
      logic signed [31:0]  sa32, sb32, sr32;
      logic [31:0]         a32, b32, t32;
      logic [63:0]         r;
      a32 = a[31:0]; b32 = b[31:0];
      sa = a; sb = b; sa32 = a32; sb32 = b32;
      r = '0;
      if (!w) begin
         case (f)
            3'd0: begin p = {64'b0, a} * {64'b0, b}; r = p[63:0]; end
            3'd1: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; r = p[127:64]; end
            3'd2: begin pa = {{64{a[63]}}, a}; pb = {64'b0, b}; p = pa * pb; r = p[127:64]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b}; r = p[127:64]; end
            3'd4: begin
               if (b == 0) r = '1;
               else if (a == MIN64 && b == '1) r = a;
               else begin sr = sa / sb; r = sr; end
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
               if (b == 0) r = a;
               else if (a == MIN64 && b == '1) r = '0;
               else begin sr = sa % sb; r = sr; end
            end
            default: r = (b == 0) ? a : a % b;
         endcase
      end else begin
         case (f)
            3'd0: begin t32 = a32 * b32; r = sx(t32); end
            3'd4: begin
               if (b32 == 0) r = '1;
               else if (a32 == 32'h80000000 && b32 == 32'hFFFFFFFF) r = sx(a32);
               else begin sr32 = sa32 / sb32; r = sx(sr32); end
            end
            3'd5: begin
               if (b32 == 0) r = '1;
               else begin t32 = a32 / b32; r = sx(t32); end
            end
            3'd6: begin
               if (b32 == 0) r = sx(a32);
               else if (a32 == 32'h80000000 && b32 == 32'hFFFFFFFF) r = '0;
               else begin sr32 = sa32 % sb32; r = sx(sr32); end
            end
            3'd7: begin
               if (b32 == 0) r = sx(a32);
               else begin t32 = a32 % b32; r = sx(t32); end
            end
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
      logic zero, ovf;
      zero = w ? (b[31:0] == 0) : (b == 0);
      ovf  = !f[0] && (w ? (a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF)
                         : (a == MIN64 && b == '1));
      if (f[2] && (zero || ovf)) return 1;
      return w ? 33 : 65;
   endfunction

   function automatic logic [63:0] pick();
      logic [63:0] v;
      v = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0: v = '0;
         1: v = 64'd1;
         2: v = '1;
         3: v = MIN64;
         4: v = v >> $urandom_range(1, 63);
         5: v = {v[63:32], 32'h80000000};
         6: v = {v[63:32], 32'hFFFFFFFF};
         default: ;
      endcase
      return v;
   endfunction

   task automatic run_op(input string tag, input logic [2:0] f, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input int hold);
      logic [63:0] exp_r;
      int          exp_l, lat;
      exp_r = ref_res(f, w, a, b);
      exp_l = ref_lat(f, w, a, b);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1; func3 = f; is_word = w; src1 = a; src2 = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
      func3 = 3'($urandom_range(0, 7)); is_word = 1'($urandom_range(0, 1));
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 200);
      chk({tag, "_latency"}, 64'(lat), 64'(exp_l));
      chk({tag, "_result"}, result, exp_r);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
      // a competing request while the result waits must be ignored
      if (hold > 0) in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_result"}, result, exp_r);
         chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
      chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [2:0]  f;
      logic        w;
      logic        seen;
      rst = 1'b1; in_valid = 1'b0; func3 = '0; is_word = 1'b0;
      src1 = '0; src2 = '0; flush = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_result", result, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("mul",    3'b000, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 0);
      run_op("mulh",   3'b001, 1'b0, MIN64, MIN64, 0);
      run_op("mulhu",  3'b011, 1'b0, MIN64, MIN64, 1);
      run_op("mulhsu", 3'b010, 1'b0, '1, 64'd2, 0);
      run_op("div",    3'b100, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 0);
      run_op("rem",    3'b110, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 0);
      run_op("divw_ovf", 3'b100, 1'b1, 64'h0000000080000000, 64'h00000000FFFFFFFF, 0);
      run_op("remuw",  3'b111, 1'b1, 64'h000000010000000A, 64'd3, 0);
      run_op("divu_z", 3'b101, 1'b0, 64'h123456789, 64'd0, 0);
      run_op("rem_z",  3'b110, 1'b0, 64'h123, 64'd0, 10);

      // flush wins over a same-cycle accept
      in_valid = 1'b1; flush = 1'b1; func3 = 3'b000; src1 = 64'd5; src2 = 64'd6;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_accept_busy", 64'(busy), 64'd0);
      chk("flush_accept_in_ready", 64'(in_ready), 64'd1);

      // flush in the middle of a divide
      in_valid = 1'b1; func3 = 3'b100; is_word = 1'b0; src1 = 64'd1000; src2 = 64'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_busy", 64'(busy), 64'd0);
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("flush_no_result", 64'(seen), 64'd0);
      run_op("after_flush", 3'b100, 1'b0, 64'd1000, 64'd7, 0);

      // reset in the middle of a multiply
      in_valid = 1'b1; func3 = 3'b000; is_word = 1'b0; src1 = 64'd11; src2 = 64'd13;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_result", result, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op("after_rst", 3'b000, 1'b0, 64'd11, 64'd13, 0);

      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         w = (f == 3'b000 || f[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
         run_op("rand", f, w, pick(), pick(), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
